// File: rtl/mem_port_arbiter.sv
// Shares one memory port between iBus and dBus with round-robin arbitration and an
// in-order owner tag FIFO for read responses. Optional macro MEM_ARB_DBUS_PRIO_EN: fixed dBus priority.
module mem_port_arbiter #(
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned AW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ibus_cmd_valid,
    output logic          ibus_cmd_ready,
    input  logic [AW-1:0] ibus_cmd_pc,
    output logic          ibus_rsp_valid,
    output logic [31:0]   ibus_rsp_instr,
    input  logic          dbus_cmd_valid,
    output logic          dbus_cmd_ready,
    input  logic [AW-1:0] dbus_cmd_addr,
    input  logic [31:0]   dbus_cmd_data,
    input  logic [3:0]    dbus_cmd_mask,
    input  logic          dbus_cmd_wr,
    output logic          dbus_rsp_valid,
    output logic [31:0]   dbus_rsp_data,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_data,
    output logic [3:0]    mem_mask,
    input  logic          mem_rsp_valid,
    input  logic [31:0]   mem_rsp_data,
    output logic          orphan_err
);
    localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CW = PW + 1;

    logic [MAX_OUTST-1:0] tag_q;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [31:0]          held_i;
    logic [31:0]          held_d;
    logic                 full;
    logic                 ibus_elig;
    logic                 dbus_elig;
    logic                 grant_d;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 head;

    // Full uses the registered count, so a full FIFO never takes a read even when popping.
    assign full      = (count == CW'(MAX_OUTST));
    assign ibus_elig = ibus_cmd_valid & ~full;
    assign dbus_elig = dbus_cmd_valid & (dbus_cmd_wr | ~full);

`ifdef MEM_ARB_DBUS_PRIO_EN
    assign grant_d = dbus_elig;
`else
    logic last_grant;

    assign grant_d = (ibus_elig & dbus_elig) ? ~last_grant : dbus_elig;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_d;
        end
    end
`endif

    assign accept = mem_valid & mem_ready;
    assign push   = accept & ~(grant_d & dbus_cmd_wr);
    assign pop    = mem_rsp_valid & (count != '0);
    assign head   = tag_q[rd_ptr];

    // Command mux and ready steering.
    always_comb begin
        mem_valid = ibus_elig | dbus_elig;
        mem_we    = 1'b0;
        mem_addr  = ibus_cmd_pc;
        mem_data  = '0;
        mem_mask  = 4'hF;
        if (grant_d) begin
            mem_we   = dbus_cmd_wr;
            mem_addr = dbus_cmd_addr;
            mem_data = dbus_cmd_data;
            mem_mask = dbus_cmd_mask;
        end
        ibus_cmd_ready = ibus_elig & ~grant_d & mem_ready;
        dbus_cmd_ready = dbus_elig & grant_d & mem_ready;
    end

    // Response routing by FIFO head; the idle bus shows its last delivered word.
    always_comb begin
        ibus_rsp_valid = pop & ~head;
        dbus_rsp_valid = pop & head;
        ibus_rsp_instr = ibus_rsp_valid ? mem_rsp_data : held_i;
        dbus_rsp_data  = dbus_rsp_valid ? mem_rsp_data : held_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            held_i     <= '0;
            held_d     <= '0;
            orphan_err <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr] <= grant_d;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
            if (mem_rsp_valid && (count == '0)) begin
                orphan_err <= 1'b1;
            end
            if (ibus_rsp_valid) begin
                held_i <= mem_rsp_data;
            end
            if (dbus_rsp_valid) begin
                held_d <= mem_rsp_data;
            end
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port 32-bit byte-addressable memory port between the core's instruction bus (iBus) and data bus (dBus). The block picks one command per cycle, keeps the owner of every outstanding read in an in-order tag FIFO, and steers each memory read response back to the bus that issued it. It sits between `riscv` and a single-port RAM, replacing the dual-port RAM arrangement when only one memory port is available.

## Interface
- `MAX_OUTST`, 4: maximum outstanding reads (tag FIFO depth); power of two, 2..16.
- `AW`, 32: address width.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ibus_cmd_valid` / `ibus_cmd_ready`  in/out  1/1  instruction fetch request handshake.
- `ibus_cmd_pc`  in  AW  fetch address.
- `ibus_rsp_valid`  out  1  fetch data valid; the core always accepts it.
- `ibus_rsp_instr`  out  32  fetched word.
- `dbus_cmd_valid` / `dbus_cmd_ready`  in/out  1/1  data request handshake.
- `dbus_cmd_addr`  in  AW  data address.
- `dbus_cmd_data`  in  32  write data.
- `dbus_cmd_mask`  in  4  byte-enable mask.
- `dbus_cmd_wr`  in  1  1 = write, 0 = read.
- `dbus_rsp_valid`  out  1  read data valid; the core always accepts it.
- `dbus_rsp_data`  out  32  read word.
- `mem_valid` / `mem_ready`  out/in  1/1  memory command handshake.
- `mem_we`, `mem_addr`, `mem_data`, `mem_mask`  out  1/AW/32/4  memory command fields.
- `mem_rsp_valid`, `mem_rsp_data`  in  1/32  memory read response; one per read, in order, none for writes.
- `orphan_err`  out  1  sticky flag: a response arrived while no read was outstanding.

## Operation
- Requester is eligible when its `cmd_valid`=1 and either:
  - the command is a write (dBus only), or
  - the tag FIFO is not full.
- Arbitration is round-robin.
  - `last_grant` register: 0 = iBus, 1 = dBus.
  - If both requesters are eligible, the one not equal to `last_grant` wins.
  - If only one is eligible, it wins.
  - `last_grant` updates only on an accepted command, i.e. `mem_valid & mem_ready`.
- Command mux:
  - `mem_valid` = the winner's eligibility.
  - Fields come from the winner.
  - iBus commands drive `mem_we`=0, `mem_data`=0, `mem_mask`=4'hF.
- Ready: the winner's `cmd_ready` = `mem_ready`; the loser's `cmd_ready` = 0.
- Tag FIFO:
  - On an accepted read, push 1 bit (0 = iBus, 1 = dBus).
  - On `mem_rsp_valid`, pop the head and route `mem_rsp_data` to `ibus_rsp_*` or `dbus_rsp_*`.
  - The response bus not selected holds `rsp_valid`=0 and its last data.
- Full: `count == MAX_OUTST` blocks reads only; writes still pass.
  - No full-bypass: when full, a push in the same cycle as a pop is not allowed, because eligibility uses the registered count.
- Simultaneous push and pop: `count` is unchanged and pointers advance independently.
- `mem_rsp_valid` with `count == 0`:
  - Data is dropped; no `rsp_valid` is raised.
  - `orphan_err` is set; it clears only on `rst`.

## Timing
- Command path is combinational: `*_cmd_valid`/fields → `mem_*`, and `mem_ready` → `*_cmd_ready`. Zero added latency.
- Response path is combinational from FIFO head + `mem_rsp_valid`. Zero added latency.
- Registered state: `last_grant`, FIFO storage and pointers, `count`, `orphan_err`, and the held response data.
- Reset values:
  - `last_grant`=1, so iBus wins the first contention.
  - `count`=0, pointers=0, `orphan_err`=0.
  - Held `ibus_rsp_instr` and `dbus_rsp_data` = 0.
  - With no valid inputs: `mem_valid`=0, both `cmd_ready`=0, both `rsp_valid`=0.
- Reset during outstanding reads: FIFO is cleared. Responses for those reads arriving after reset set `orphan_err`; they are never delivered.
- A command that is presented but not accepted must be held stable by the requester. The grant may switch away from it only if it drops `valid`, which a compliant core does not do.

## Configuration
- `MEM_ARB_DBUS_PRIO_EN`:
  - Defined: dBus has fixed priority whenever it is eligible; `last_grant` is unused (tied off). iBus may starve under continuous dBus traffic.
  - Undefined: round-robin as specified above.

## Test plan
- Reset, then iBus read 0x100 alone with `mem_ready`=1 → `mem_valid`=1, `mem_addr`=0x100, `mem_we`=0, `mem_mask`=F. Memory returns 0xDEADBEEF → `ibus_rsp_valid`=1, `ibus_rsp_instr`=0xDEADBEEF, `dbus_rsp_valid`=0.
- Both buses request reads every cycle for 8 cycles → grants alternate I,D,I,D… starting with iBus. Responses routed in issue order.
  - With `MEM_ARB_DBUS_PRIO_EN`: all 8 grants go to dBus.
- `MAX_OUTST`=4, 4 dBus reads with no responses → 5th read gets `dbus_cmd_ready`=0. A dBus write (addr 0x40, data 0x12345678, mask 0x3) is still accepted with `mem_we`=1. After one response, the read is accepted.
- `mem_ready`=0 for 3 cycles with both valid → both `cmd_ready`=0 and `last_grant` unchanged. On release, the expected round-robin winner is accepted.
- Issue 2 reads, assert `rst` for 1 cycle, then deliver 2 `mem_rsp_valid` pulses → no `rsp_valid` on either bus, `orphan_err`=1 until the next `rst`.
